// File: rtl/uart_rx_byte_pkg.sv
// Shared constants, FSM state encoding and the majority-vote helper
// used across the UART receive path.
package uart_rx_byte_pkg;

  localparam int CLKS_PER_BIT_DEF = 87;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Valid/ready byte stream from the UART receiver to the byte buffer.
interface uart_rx_byte_if;
  import uart_rx_byte_pkg::*;

  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input  m_ready);
  modport slave  (input  m_data, input  m_valid, output m_ready);

endinterface

// File: rtl/uart_rx_byte_rx_sync_filter.sv
// Two-flop synchronizer followed by a 3-tap majority filter on the raw rx pin.
// Everything resets to 1 so a reset never looks like a start edge.
module uart_rx_byte_rx_sync_filter
  import uart_rx_byte_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_f_o
);

  logic [1:0] sync_q;
  logic [2:0] taps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      taps_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      taps_q <= {taps_q[1:0], sync_q[1]};
    end
  end

  assign rx_f_o = majority3(taps_q);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: start/data/stop FSM, one-byte holding register on a
// valid/ready stream, plus frame-error and overrun debug pulses.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_i,
  uart_rx_byte_if.master  m_if,
  output logic            frame_err_o,
  output logic            overrun_o,
  output logic            busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_f;
  rx_state_e            state_q,     state_d;
  logic [CW-1:0]        bit_cnt_q,   bit_cnt_d;
  logic [IW-1:0]        idx_q,       idx_d;
  logic [DATA_BITS-1:0] shreg_q,     shreg_d;
  logic                 deliver_q,   deliver_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic [DATA_BITS-1:0] m_data_q,    m_data_d;
  logic                 m_valid_q,   m_valid_d;
  logic [CW-1:0]        cnt_next;

  uart_rx_byte_rx_sync_filter u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx_i),
    .rx_f_o (rx_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign cnt_next = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_f) state_d = ST_START;
      end
      ST_START: begin
        bit_cnt_d = cnt_next;
        // Half-bit check rejects glitches and aligns later samples to bit centres.
        if (bit_cnt_q == CNT_HALF) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = rx_f ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        bit_cnt_d = cnt_next;
        if (bit_cnt_q == CNT_LAST) begin
          shreg_d[idx_q] = rx_f;
          idx_d          = idx_q + IW'(1);
          if (idx_q == IDX_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        bit_cnt_d = cnt_next;
        if (bit_cnt_q == CNT_LAST) begin
          if (rx_f) begin
            deliver_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        bit_cnt_d = '0;
        if (rx_f) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (m_valid_q && m_if.m_ready) m_valid_d = 1'b0;
    // A load in the same cycle as an accept wins and keeps the stream valid.
    if (deliver_q) begin
      if (!m_valid_q || m_if.m_ready) begin
        m_data_d  = shreg_q;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign m_if.m_data  = m_data_q;
  assign m_if.m_valid = m_valid_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed-vector bench for uart_rx_byte with a queue-based scoreboard monitor.
module tb_uart_rx_byte;

  localparam int CPB       = 16;
  localparam int FLAG_FERR = 1;
  localparam int FLAG_OVR  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_byte_if m_if();

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx),
    .m_if        (m_if),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_bytes[$];
  int         exp_flags[$];

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endfunction

  // Monitor: every accepted beat and every flag pulse is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_bytes.size() == 0) chk("unexpected_byte", {24'd0, m_if.m_data}, 32'hFFFF_FFFF);
        else chk("byte", {24'd0, m_if.m_data}, {24'd0, exp_bytes.pop_front()});
      end
      if (frame_err) begin
        if (exp_flags.size() == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
        else chk("flag_frame_err", FLAG_FERR, exp_flags.pop_front());
      end
      if (overrun) begin
        if (exp_flags.size() == 0) chk("unexpected_overrun", 32'd1, 32'd0);
        else chk("flag_overrun", FLAG_OVR, exp_flags.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_flags.size() != 0) && n < 400) begin
      tick(1);
      n++;
    end
    chk(name, exp_bytes.size() + exp_flags.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"},   {31'd0, m_if.m_valid}, 0);
    chk({tag, "_m_data"},    {24'd0, m_if.m_data},  0);
    chk({tag, "_frame_err"}, {31'd0, frame_err},    0);
    chk({tag, "_overrun"},   {31'd0, overrun},      0);
    chk({tag, "_busy"},      {31'd0, busy},         0);
  endtask

  initial begin
    m_if.m_ready = 1'b0;
    rx    = 1'b1;
    rst_n = 1'b0;
    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2 * CPB);

    // 1: single byte, consumer always ready
    m_if.m_ready = 1'b1;
    exp_bytes.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        int n;
        n = 0;
        while (!m_if.m_valid && n < 300) begin
          @(negedge clk);
          n++;
        end
        chk("t1_valid_seen", {31'd0, m_if.m_valid}, 1);
        @(negedge clk);
        chk("t1_valid_one_cycle", {31'd0, m_if.m_valid}, 0);
      end
    join
    tick(2 * CPB);
    drain("t1_drain");

    // 2: short low glitch is a false start
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3);
    chk("t2_busy_in_start", {31'd0, busy}, 1);
    tick(2 * CPB);
    chk("t2_busy_back_idle", {31'd0, busy}, 0);
    chk("t2_no_valid", {31'd0, m_if.m_valid}, 0);

    // 3: bad stop bit, line held low, then a good byte
    exp_flags.push_back(FLAG_FERR);
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    tick(CPB);
    chk("t3_busy_in_break", {31'd0, busy}, 1);
    rx = 1'b1;
    tick(2 * CPB);
    chk("t3_no_valid", {31'd0, m_if.m_valid}, 0);
    drain("t3_ferr_drain");
    exp_bytes.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick(2 * CPB);
    drain("t3_byte_drain");

    // 4: consumer stalled -> second byte overruns
    m_if.m_ready = 1'b0;
    exp_bytes.push_back(8'h01);
    exp_flags.push_back(FLAG_OVR);
    send_frame(8'h01, 1'b1);
    tick(CPB);
    send_frame(8'h02, 1'b1);
    tick(2 * CPB);
    chk("t4_valid_held", {31'd0, m_if.m_valid}, 1);
    chk("t4_data_held", {24'd0, m_if.m_data}, 32'h01);
    chk("t4_overrun_seen", exp_flags.size(), 0);
    m_if.m_ready = 1'b1;
    tick(1);
    chk("t4_valid_falls", {31'd0, m_if.m_valid}, 0);
    drain("t4_drain");

    // 5: back-to-back frames
    exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hAA);
    exp_bytes.push_back(8'hFF);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(2 * CPB);
    drain("t5_drain");

    // 6: reset in the middle of 0x77, then 0x42
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    rst_n = 1'b0;
    tick(2);
    chk_reset_outputs("t6_in_reset");
    rst_n = 1'b1;
    tick(2 * CPB);
    chk("t6_idle_after_reset", {31'd0, busy}, 0);
    exp_bytes.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    tick(2 * CPB);
    drain("t6_drain");
    chk("t6_last_data", {24'd0, m_if.m_data}, 32'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
